dram_ctrl: RTL and testbench

Data-memory controller between the core's load/store unit, a debug/loader port and the single-port word DRAM (16-bit word address, 32-bit data, synchronous write, asynchronous read, read data undefined while write enable is high). It converts byte-addressed RV32 loads and stores into word accesses. Sub-word stores become a two-cycle read-modify-write. It arbitrates the one DRAM port between the core and the debug port, and bounds debug starvation.

---
 rtl/dram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dram_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// -----------------------------------------------------------------------------
// dram_ctrl
// Data-memory controller sitting between the core load/store unit, a debug /
// loader port and a single-port word DRAM (asynchronous read, synchronous
// write). Byte-addressed RV32 loads/stores are turned into word accesses;
// sub-word stores become a two-cycle read-modify-write. The single DRAM port
// is shared with the debug port, whose starvation is bounded by STARVE_LIMIT.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/funct3/addr/wdata core request (held until cpu_ready)
//   cpu_rdata/ready/misalign     core completion, load data, error flag
//   dbg_req/we/addr/wdata        debug word request (held until dbg_ack)
//   dbg_rdata/ack                debug completion and read data
//   mem_a/we/din, mem_spo        DRAM port
// -----------------------------------------------------------------------------
module dram_ctrl #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [2:0]  cpu_funct3,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        cpu_misalign,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [15:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata,
   output logic        dbg_ack,
   output logic [15:0] mem_a,
   output logic        mem_we,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_spo
);

   localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT - 1);

   typedef enum logic {IDLE, RMW_WR} state_t;

   state_t        state, state_n;
   logic [CW-1:0] starve_cnt, starve_cnt_n;
   logic [31:0]   merge, merge_n;

   // Upper address bits are outside the 256 KiB data window and ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^cpu_addr[31:18];

   // Access decode
   logic [15:0] word_idx;
   logic        is_byte, is_half, is_word, bad_code, misalign;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_val, merged;

   always_comb begin
      word_idx = cpu_addr[17:2];
      is_byte  = (cpu_funct3[1:0] == 2'b00);
      is_half  = (cpu_funct3[1:0] == 2'b01);
      is_word  = (cpu_funct3 == 3'b010);
      bad_code = (cpu_funct3 == 3'b011) || (cpu_funct3 == 3'b110) || (cpu_funct3 == 3'b111);
      misalign = bad_code || (is_half && cpu_addr[0]) || (is_word && (cpu_addr[1:0] != 2'b00));

      ld_byte = mem_spo[{cpu_addr[1:0], 3'b000} +: 8];
      ld_half = cpu_addr[1] ? mem_spo[31:16] : mem_spo[15:0];
      // funct3[2] set selects zero extension (lbu/lhu).
      if (is_byte)
         load_val = {{24{~cpu_funct3[2] & ld_byte[7]}}, ld_byte};
      else if (is_half)
         load_val = {{16{~cpu_funct3[2] & ld_half[15]}}, ld_half};
      else
         load_val = mem_spo;

      // Replace the target lane of the word just read with the store data.
      merged = mem_spo;
      if (is_byte)
         merged[{cpu_addr[1:0], 3'b000} +: 8] = cpu_wdata[7:0];
      else
         merged[{cpu_addr[1], 4'b0000} +: 16] = cpu_wdata[15:0];
   end

   // Next state and combinational outputs
   always_comb begin
      // NOTE: every output and next-state variable is given a default before
      // any branch so no path leaves one unassigned, which would infer a latch.
      state_n      = state;
      merge_n      = merge;
      cpu_rdata    = '0;
      cpu_ready    = 1'b0;
      cpu_misalign = 1'b0;
      dbg_rdata    = '0;
      dbg_ack      = 1'b0;
      mem_a        = '0;
      mem_we       = 1'b0;
      mem_din      = '0;

      // Outputs are forced low during reset so an RMW write is aborted too.
      if (!rst) begin
         unique case (state)
            IDLE: begin
               if (dbg_req && (!cpu_req || starve_cnt == CNT_MAX)) begin
                  mem_a     = dbg_addr;
                  mem_we    = dbg_we;
                  mem_din   = dbg_wdata;
                  dbg_rdata = mem_spo;
                  dbg_ack   = 1'b1;
               end else if (cpu_req) begin
                  if (misalign) begin
                     cpu_ready    = 1'b1;
                     cpu_misalign = 1'b1;
                  end else if (!cpu_we) begin
                     mem_a     = word_idx;
                     cpu_rdata = load_val;
                     cpu_ready = 1'b1;
                  end else if (is_word) begin
                     mem_a     = word_idx;
                     mem_we    = 1'b1;
                     mem_din   = cpu_wdata;
                     cpu_ready = 1'b1;
                  end else begin
                     // Sub-word store: read cycle, merge captured from mem_spo
                     // while mem_we is low.
                     mem_a   = word_idx;
                     merge_n = merged;
                     state_n = RMW_WR;
                  end
               end
            end
            RMW_WR: begin
               // The core holds its request stable, so cpu_addr still names
               // the word read in the previous cycle.
               mem_a     = word_idx;
               mem_we    = 1'b1;
               mem_din   = merge;
               cpu_ready = 1'b1;
               state_n   = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Starvation counter: counts cycles a debug request waits, saturating.
   always_comb begin
      starve_cnt_n = starve_cnt;
      if (!dbg_req || dbg_ack)
         starve_cnt_n = '0;
      else if (starve_cnt != CNT_MAX)
         starve_cnt_n = starve_cnt + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         merge      <= '0;
      end else begin
         state      <= state_n;
         starve_cnt <= starve_cnt_n;
         merge      <= merge_n;
      end
   end

endmodule

// File: tb/tb_dram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dram_ctrl
// Self-checking bench for dram_ctrl. A behavioural DRAM is attached to the
// memory port; an independent reference memory tracks what the byte-level
// store/load rules say the memory should contain, and every completion is
// compared against it. Directed cases cover the listed scenarios, followed by
// randomized core and debug traffic.
// -----------------------------------------------------------------------------
module tb_dram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [2:0]  cpu_funct3;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ready, cpu_misalign;
   logic        dbg_req, dbg_we;
   logic [15:0] dbg_addr;
   logic [31:0] dbg_wdata, dbg_rdata;
   logic        dbg_ack;
   logic [15:0] mem_a;
   logic        mem_we;
   logic [31:0] mem_din, mem_spo;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] dram    [0:65535];
   logic [31:0] ref_mem [0:65535];

   always #5 clk = ~clk;

   dram_ctrl #(.STARVE_LIMIT(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ready(cpu_ready), .cpu_misalign(cpu_misalign),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_a(mem_a), .mem_we(mem_we), .mem_din(mem_din), .mem_spo(mem_spo)
   );

   // Behavioural DRAM: async read (garbage while writing), sync write.
   assign mem_spo = mem_we ? 32'hBAD0_BAD0 : dram[mem_a];
   always @(posedge clk) if (mem_we) dram[mem_a] <= mem_din;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Reference rules ---------------------------------------------------------
   function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'd0, 3'd4: return 1'b0;
         3'd1, 3'd5: return a[0];
         3'd2:       return a[1:0] != 0;
         default:    return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w;
      int unsigned v;
      w = ref_mem[a[17:2]];
      case (f3)
         3'd0, 3'd4: begin
            v = (w >> (8 * a[1:0])) % 256;
            if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
         end
         3'd1, 3'd5: begin
            v = (w >> (16 * a[1])) % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
      logic [31:0] w, mask;
      int sh;
      w = ref_mem[a[17:2]];
      if (f3 == 3'd2) return d;
      if (f3 == 3'd0) begin
         sh   = 8 * a[1:0];
         mask = 32'hFF << sh;
         return (w & ~mask) | ((d & 32'hFF) << sh);
      end
      sh   = 16 * a[1];
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((d & 32'hFFFF) << sh);
   endfunction

   // One core access. Inputs change #1 after a rising edge; outputs are
   // sampled on the falling edge.
   task automatic cpu_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
      bit          mis;
      int          lat, cyc;
      bit          seen;
      logic [31:0] exp_word, r_rdata, r_din;
      logic [15:0] r_a;
      logic        r_mis, r_we;
      mis      = ref_misaligned(f3, a);
      lat      = (!mis && we && f3 != 3'd2) ? 2 : 1;
      exp_word = ref_store(f3, a, d);
      cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = d;
      seen = 0; cyc = 0;
      r_rdata = '0; r_din = '0; r_a = '0; r_mis = 0; r_we = 0;
      while (!seen && cyc < 6) begin
         @(negedge clk);
         cyc++;
         check("no_dbg_during_cpu", {31'd0, dbg_ack}, 32'd0);
         if (cpu_ready) begin
            seen = 1;
            r_rdata = cpu_rdata; r_mis = cpu_misalign; r_we = mem_we;
            r_din = mem_din; r_a = mem_a;
         end else begin
            check("rmw_read_we", {31'd0, mem_we}, 32'd0);
         end
         @(posedge clk); #1;
      end
      cpu_req = 1'b0;
      if (!seen) begin
         check("cpu_timeout", 32'd0, 32'd1);
         return;
      end
      check("cpu_latency", cyc, lat);
      check("cpu_misalign", {31'd0, r_mis}, {31'd0, mis});
      check("mem_we_final", {31'd0, r_we}, {31'd0, (we && !mis)});
      if (mis || !we) check("cpu_rdata", r_rdata, mis ? 32'd0 : ref_load(f3, a));
      if (we && !mis) begin
         check("store_din", r_din, exp_word);
         check("store_addr", {16'd0, r_a}, {16'd0, a[17:2]});
         ref_mem[a[17:2]] = exp_word;
      end
   endtask

   task automatic dbg_op(input logic we, input logic [15:0] a, input logic [31:0] d);
      int cyc;
      bit seen;
      logic [31:0] r_rd;
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
      seen = 0; cyc = 0; r_rd = '0;
      while (!seen && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (dbg_ack) begin
            seen = 1; r_rd = dbg_rdata;
            check("dbg_no_cpu_ready", {31'd0, cpu_ready}, 32'd0);
         end
         @(posedge clk); #1;
      end
      dbg_req = 1'b0;
      check("dbg_ack_seen", {31'd0, seen}, 32'd1);
      if (seen && !we) check("dbg_rdata", r_rd, ref_mem[a]);
      if (seen && we) ref_mem[a] = d;
   endtask

   initial begin
      logic [31:0] outs;
      int ack_cyc;
      for (int i = 0; i < 65536; i++) begin
         dram[i]    = (i < 64) ? $urandom : 32'd0;
         ref_mem[i] = dram[i];
      end
      // Reset with both requesters active: all outputs must be zero.
      rst = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_funct3 = 3'd0; cpu_addr = 32'h42; cpu_wdata = 32'h55;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h3; dbg_wdata = 32'h1234;
      @(negedge clk);
      outs = cpu_rdata | dbg_rdata | mem_din | {16'd0, mem_a} |
             {28'd0, mem_we, cpu_ready, cpu_misalign, dbg_ack};
      check("reset_outputs", outs, 32'd0);
      @(posedge clk); #1;
      cpu_req = 1'b0; dbg_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Word store/load.
      cpu_op(1, 3'd2, 32'h40, 32'hDEADBEEF);
      cpu_op(0, 3'd2, 32'h40, 32'h0);
      check("sw_lw_dram", dram[16'h10], 32'hDEADBEEF);

      // Byte store and loads.
      cpu_op(1, 3'd2, 32'h40, 32'h11223344);
      cpu_op(1, 3'd0, 32'h42, 32'h000000A5);
      check("sb_merge_const", ref_mem[16'h10], 32'h11A53344);
      check("lb_const", ref_load(3'd0, 32'h42), 32'hFFFFFFA5);
      cpu_op(0, 3'd0, 32'h42, 0);
      cpu_op(0, 3'd4, 32'h42, 0);
      cpu_op(0, 3'd1, 32'h42, 0);
      check("lh_const", ref_load(3'd1, 32'h42), 32'h000011A5);

      // Misalignment.
      cpu_op(0, 3'd2, 32'h41, 0);
      cpu_op(1, 3'd1, 32'h43, 32'hFFFF);
      check("misalign_unchanged", dram[16'h10], 32'h11A53344);

      // Debug starvation against streaming lw.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'd2; cpu_addr = 32'h40; cpu_wdata = 0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h5; dbg_wdata = 32'hCAFE0001;
      ack_cyc = 0;
      for (int c = 1; c <= 12 && ack_cyc == 0; c++) begin
         @(negedge clk);
         if (dbg_ack) begin
            ack_cyc = c;
            check("starve_cpu_ready_low", {31'd0, cpu_ready}, 32'd0);
         end else begin
            check("stream_lw_ready", {31'd0, cpu_ready}, 32'd1);
         end
         @(posedge clk); #1;
      end
      dbg_req = 1'b0; cpu_req = 1'b0;
      check("starve_ack_cycle", ack_cyc, 8);
      ref_mem[5] = 32'hCAFE0001;
      cpu_op(0, 3'd2, 32'h14, 0);
      dbg_op(0, 16'h5, 0);

      // Debug pending during an sb: not granted in RMW_WR, served afterwards.
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h10;
      cpu_op(1, 3'd0, 32'h41, 32'h7E);
      dbg_op(0, 16'h10, 0);

      // Reset mid-RMW.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_funct3 = 3'd0; cpu_addr = 32'h42; cpu_wdata = 32'h77;
      @(negedge clk);
      check("midrmw_read_we", {31'd0, mem_we}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      outs = cpu_rdata | dbg_rdata | mem_din | {16'd0, mem_a} |
             {28'd0, mem_we, cpu_ready, cpu_misalign, dbg_ack};
      check("midrmw_outputs", outs, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; cpu_req = 1'b0;
      cpu_op(0, 3'd2, 32'h40, 0);

      // Randomized traffic over a small window.
      for (int n = 0; n < 300; n++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         logic        we;
         a  = $urandom_range(0, 63) * 4 + $urandom_range(0, 3) + ($urandom << 18);
         we = $urandom_range(0, 1);
         f3 = 3'($urandom_range(0, 7));
         if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 & 3'd3;
         if ($urandom_range(0, 5) == 0)
            dbg_op($urandom_range(0, 1), 16'($urandom_range(0, 63)), $urandom);
         else
            cpu_op(we, f3, a, $urandom);
      end

      // Final memory sweep against the reference.
      for (int i = 0; i < 64; i++) check($sformatf("final_mem_%0d", i), dram[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
